lock_code_sender: RTL and testbench
===================================

# lock_code_sender

Initiator side of the two-button digital lock: replays a stored code as timed `w0`/`w1` button pulses, then watches the lock's `L` output and reports whether the lock opened. It is used to drive the `FSM` lock block, either on chip as an auto-unlock sequencer or in benches as a reusable stimulus engine. It replaces hand-written press/release sequences.

## Interface

Parameters:
- `CODE_LEN`, 3: number of presses in the code; must be at least 1.
- `PRESS_CYCLES`, 1: cycles each button is held high; must be at least 1.
- `GAP_CYCLES`, 1: cycles with both buttons low after each press; must be at least 1.
- `TIMEOUT_CYCLES`, 8: maximum number of `L` samples taken before the sequence is declared failed; must be at least 1.

Ports:
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request to send the code; sampled only in IDLE.
- `code` input `CODE_LEN`: press sequence, sent LSB first; 0 = press `w0`, 1 = press `w1`. Latched when `start` is accepted.
- `L` input 1: unlock indication from the lock.
- `w0` output 1: button 0 drive, registered.
- `w1` output 1: button 1 drive, registered.
- `busy` output 1: high from the accepted `start` until `done`.
- `done` output 1: one-cycle completion pulse.
- `unlocked` output 1: result, valid with `done`; held until the next accepted `start`.

## Operation

- States are IDLE, PRESS, GAP and WAIT_L.
- **IDLE:** `w0`, `w1` and `busy` are 0. If `start`=1 on an edge:
  - latch `code`;
  - clear the press index and `unlocked`;
  - set `busy`=1;
  - go to PRESS.
- **PRESS:**
  - Drive `w1` high if `code_q[idx]`=1; otherwise drive `w0` high. Exactly one button is high.
  - Stay for `PRESS_CYCLES` cycles, then go to GAP.
- **GAP:**
  - Both buttons are low for `GAP_CYCLES` cycles.
  - Then, if `idx` < `CODE_LEN`-1, increment `idx` and go to PRESS.
  - Otherwise go to WAIT_L.
- **WAIT_L:** sample `L` on each edge.
  - On the first sample with `L`=1: `done`=1, `unlocked`=1, `busy`=0, go to IDLE.
  - If all `TIMEOUT_CYCLES` samples are 0: at the last one, `done`=1, `unlocked`=0, `busy`=0, go to IDLE.
- `start` is ignored while `busy`=1; it is not queued.
- `L` is ignored outside WAIT_L.
- Widths:
  - `idx` is `$clog2(CODE_LEN)` bits, minimum 1.
  - The phase/timeout counter is sized for `max(PRESS_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)`.
  - Counters never wrap in normal operation.

## Timing

- Reset (`reset`=0) immediately forces:
  - state to IDLE;
  - `w0`=`w1`=`busy`=`done`=`unlocked`=0;
  - counters and `code_q` to 0.
- Reset mid-sequence drops the buttons asynchronously. No `done` pulse is produced.
- Let edge E0 be the edge that accepts `start`. The first press is visible immediately after E0.
- WAIT_L begins at edge E0 + `CODE_LEN`·(`PRESS_CYCLES`+`GAP_CYCLES`).
- With the defaults, WAIT_L begins at E0+6:
  - `w0` is high during cycles E0..E1;
  - `w1` is high during cycles E2..E3 and E4..E5.
- Success: `done` is high for the one cycle after the first edge in WAIT_L that samples `L`=1.
- Failure with the defaults: `done` is high after edge E0+13.
- `start`=1 while `done`=1 is accepted, because the state is already IDLE.

## Configuration

- `LOCK_SENDER_ABORT_EN` defined:
  - adds input port `abort`, 1 bit;
  - when `abort`=1 on an edge with `busy`=1, go to IDLE with `w0`=`w1`=0, `done`=1, `unlocked`=0 on the following cycle;
  - `abort` takes priority over a same-edge `L`=1 in WAIT_L;
  - `abort` is ignored in IDLE.
- Not defined: there is no `abort` port, and sequences run only to success or timeout.

## Test plan

1. **Reset:** hold `reset`=0 for 2 cycles with `start`=1 → `w0`=`w1`=`busy`=`done`=`unlocked`=0 throughout, and there is no activity after release until `start` is pulsed again.
2. **Correct code:** `code`=3'b110, 1-cycle `start` at E0, driving the lock FSM → `w0` high for 1 cycle after E0, `w1` high after E2 and after E4, `L`=1 sampled at E6, then `done`=1 and `unlocked`=1 after E6, `busy`=0.
3. **Wrong code:** `code`=3'b111 with `L` held 0 → the full press pattern is sent, then `done`=1 and `unlocked`=0 after E13.
4. **Busy handling:** hold `start`=1 continuously → a second sequence starts on the edge after `done`, never earlier, and `unlocked` clears when it is accepted.
5. **Mid-sequence reset:** assert `reset`=0 while `w1`=1 → `w1` and `busy` drop without waiting for a clock edge, `done` stays 0, and a new `start` replays from press 0.
6. **Abort (`LOCK_SENDER_ABORT_EN`):** `abort`=1 during the second GAP → one `done` pulse with `unlocked`=0, then IDLE.

Source files
------------

// File: rtl/lock_code_sender.sv
// Replays a stored press code as timed w0/w1 pulses, then watches L and reports the outcome.
// Optional abort input is enabled by defining LOCK_SENDER_ABORT_EN.
module lock_code_sender #(
    parameter int CODE_LEN       = 3,
    parameter int PRESS_CYCLES   = 1,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CODE_LEN-1:0] code,
    input  logic                L,
`ifdef LOCK_SENDER_ABORT_EN
    input  logic                abort,
`endif
    output logic                w0,
    output logic                w1,
    output logic                busy,
    output logic                done,
    output logic                unlocked
);

    localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int CNT_MAX = (PRESS_CYCLES > GAP_CYCLES)
                           ? ((PRESS_CYCLES > TIMEOUT_CYCLES) ? PRESS_CYCLES : TIMEOUT_CYCLES)
                           : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CODE_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRESS  = 2'd1,
        S_GAP    = 2'd2,
        S_WAIT_L = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [IDX_W-1:0]    w_idx_inc;
    logic [CODE_LEN-1:0] r_code;
    logic [CODE_LEN-1:0] w_code_nxt;
    logic                r_w0;
    logic                r_w1;
    logic                r_busy;
    logic                r_done;
    logic                r_unlocked;
    logic                w_w0_nxt;
    logic                w_w1_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_unlocked_nxt;
    logic                w_finish;
    logic                w_result;
    logic                w_abort;

`ifdef LOCK_SENDER_ABORT_EN
    assign w_abort = abort & r_busy;
`else
    assign w_abort = 1'b0;
`endif

    assign w_idx_inc = r_idx + IDX_W'(1);
    assign w0        = r_w0;
    assign w1        = r_w1;
    assign busy      = r_busy;
    assign done      = r_done;
    assign unlocked  = r_unlocked;

    // Next-state, counter and registered-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_code_nxt     = r_code;
        w_w0_nxt       = 1'b0;
        w_w1_nxt       = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_unlocked_nxt = r_unlocked;
        w_finish       = 1'b0;
        w_result       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_code_nxt     = code;
                    w_idx_nxt      = IDX_W'(0);
                    w_cnt_nxt      = CNT_W'(0);
                    w_unlocked_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_PRESS;
                    w_w1_nxt       = code[0];
                    w_w0_nxt       = ~code[0];
                end else begin
                    w_busy_nxt     = 1'b0;
                end
            end
            S_PRESS: begin
                if (r_cnt == PRESS_LAST) begin
                    w_cnt_nxt   = CNT_W'(0);
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_w1_nxt    = r_code[r_idx];
                    w_w0_nxt    = ~r_code[r_idx];
                end
            end
            S_GAP: begin
                if (r_cnt != GAP_LAST) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else if (r_idx < IDX_LAST) begin
                    w_cnt_nxt   = CNT_W'(0);
                    w_idx_nxt   = w_idx_inc;
                    w_state_nxt = S_PRESS;
                    w_w1_nxt    = r_code[w_idx_inc];
                    w_w0_nxt    = ~r_code[w_idx_inc];
                end else if (L) begin
                    // The closing gap edge is the entry edge of WAIT_L and counts as its first L sample.
                    w_finish = 1'b1;
                    w_result = 1'b1;
                end else if (TO_LAST == CNT_W'(0)) begin
                    w_finish = 1'b1;
                    w_result = 1'b0;
                end else begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_WAIT_L;
                end
            end
            S_WAIT_L: begin
                if (L) begin
                    w_finish = 1'b1;
                    w_result = 1'b1;
                end else if (r_cnt == TO_LAST) begin
                    w_finish = 1'b1;
                    w_result = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (w_abort) begin
            w_state_nxt    = S_IDLE;
            w_cnt_nxt      = CNT_W'(0);
            w_w0_nxt       = 1'b0;
            w_w1_nxt       = 1'b0;
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b1;
            w_unlocked_nxt = 1'b0;
        end else if (w_finish) begin
            w_state_nxt    = S_IDLE;
            w_cnt_nxt      = CNT_W'(0);
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b1;
            w_unlocked_nxt = w_result;
        end else begin
            w_done_nxt     = 1'b0;
        end
    end

    // State, counters, latched code and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= CNT_W'(0);
            r_idx      <= IDX_W'(0);
            r_code     <= CODE_LEN'(0);
            r_w0       <= 1'b0;
            r_w1       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_unlocked <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_code     <= w_code_nxt;
            r_w0       <= w_w0_nxt;
            r_w1       <= w_w1_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_unlocked <= w_unlocked_nxt;
        end
    end

endmodule

// File: tb/tb_lock_code_sender.sv
// Scoreboard bench for lock_code_sender: randomized codes and L timing against a cycle-level reference.
// Define LOCK_SENDER_ABORT_EN to also exercise the abort input.
module tb_lock_code_sender;

    localparam int CL  = 3;
    localparam int PC  = 1;
    localparam int GC  = 1;
    localparam int TO  = 8;
    localparam int PER = PC + GC;
    localparam int WL  = CL * PER;

    typedef struct {
        logic [CL-1:0] code;
        int            lat;
        logic          res;
    } item_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [CL-1:0] code;
    logic          L;
    logic          abort;
    logic          w0;
    logic          w1;
    logic          busy;
    logic          done;
    logic          unlocked;

    item_t exp_q[$];
    int    n_cmp;
    int    n_bad;
    int    k;
    bit    in_txn;
    logic  last_res;

    lock_code_sender #(
        .CODE_LEN       (CL),
        .PRESS_CYCLES   (PC),
        .GAP_CYCLES     (GC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .code     (code),
        .L        (L),
`ifdef LOCK_SENDER_ABORT_EN
        .abort    (abort),
`endif
        .w0       (w0),
        .w1       (w1),
        .busy     (busy),
        .done     (done),
        .unlocked (unlocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: press index k/PER is held for the first PC cycles of each period, then silence.
    function automatic logic [1:0] exp_btn(input logic [CL-1:0] c, input int kk);
        logic [CL-1:0] cc;
        cc = c;
        if (kk < WL && (kk % PER) < PC) begin
            return cc[kk / PER] ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    // Monitor: checks every cycle against the head of the expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_outputs", {27'd0, w0, w1, busy, done, unlocked}, 32'd0);
            in_txn = 1'b0;
            exp_q.delete();
            last_res = 1'b0;
        end else if (busy) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                k = 0;
                chk("busy_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            end
            if (exp_q.size() > 0) begin
                chk("buttons", {30'd0, w0, w1}, {30'd0, exp_btn(exp_q[0].code, k)});
                chk("flags_while_busy", {30'd0, done, unlocked}, 32'd0);
            end
            k++;
        end else if (done) begin
            chk("done_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                item_t h;
                h = exp_q.pop_front();
                chk("latency", k, h.lat);
                chk("unlocked", {31'd0, unlocked}, {31'd0, h.res});
                chk("buttons_at_done", {30'd0, w0, w1}, 32'd0);
                last_res = h.res;
            end
            in_txn = 1'b0;
        end else begin
            chk("idle", {28'd0, in_txn, w0, w1, unlocked}, {28'd0, 1'b0, 2'b00, last_res});
            in_txn = 1'b0;
        end
    end

    // s_hit: first WAIT_L sample index with L=1 (-1 = never); abort_at: edge offset of abort (0 = none).
    task automatic run_txn(input logic [CL-1:0] c, input int s_hit, input int abort_at, input bit hold);
        item_t it;
        int    lat;
        logic  res;
        if (s_hit >= 0) begin
            lat = WL + s_hit;
            res = 1'b1;
        end else begin
            lat = WL + TO - 1;
            res = 1'b0;
        end
        if (abort_at > 0 && abort_at <= lat) begin
            lat = abort_at;
            res = 1'b0;
        end
        it.code = c;
        it.lat  = lat;
        it.res  = res;
        exp_q.push_back(it);
        code  = c;
        start = 1'b1;
        @(posedge clk); #1;
        for (int m = 1; m <= lat; m++) begin
            int si;
            si    = m - WL;
            code  = CL'($urandom);
            start = hold ? 1'b1 : 1'($urandom);
            if (si < 0)                    L = 1'($urandom);
            else if (s_hit < 0 || si < s_hit) L = 1'b0;
            else                           L = 1'b1;
            abort = (m == abort_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        L     = 1'b0;
        abort = 1'b0;
    endtask

    function automatic int rand_hit();
        int r;
        r = $urandom_range(0, TO);
        return (r == TO) ? -1 : r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        k        = 0;
        in_txn   = 1'b0;
        last_res = 1'b0;
        reset    = 1'b0;
        start    = 1'b1;
        code     = 3'b101;
        L        = 1'b1;
        abort    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        L     = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        run_txn(3'b110, 0, 0, 1'b0);
        run_txn(3'b111, -1, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_txn(CL'($urandom), rand_hit(), 0, 1'b1);
        end
        for (int i = 0; i < 20; i++) begin
            run_txn(CL'($urandom), rand_hit(), 0, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        begin
            item_t it;
            it.code = 3'b110;
            it.lat  = WL;
            it.res  = 1'b1;
            exp_q.push_back(it);
        end
        code  = 3'b110;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("w1_before_reset", {31'd0, w1}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_drop", {28'd0, w0, w1, busy, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_txn(3'b110, 2, 0, 1'b0);

`ifdef LOCK_SENDER_ABORT_EN
        run_txn(3'b110, -1, 4, 1'b0);
        run_txn(3'b011, 0, WL, 1'b0);
        run_txn(CL'($urandom), rand_hit(), $urandom_range(1, WL + TO - 1), 1'b0);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
